// File: rtl/flex_down_timer_if.sv
// ---------------------------------------------------------------------------
// flex_down_timer_if
// Control/status bundle between a controller and the flex_down_timer.
//   clear        : synchronous abort back to idle
//   start        : request to load load_val and begin counting
//   count_enable : one decrement tick per high cycle
//   load_val     : period, sampled only when start is accepted
//   auto_reload  : periodic-mode request (used only in reload builds)
//   count_out    : remaining ticks
//   busy         : high while the timer is counting
//   done         : one-cycle completion strobe
// Modports: master = controller side, slave = timer side.
// ---------------------------------------------------------------------------
interface flex_down_timer_if #(
   parameter int NUM_CNT_BITS = 9
);
   logic                    clear;
   logic                    start;
   logic                    count_enable;
   logic [NUM_CNT_BITS-1:0] load_val;
   logic                    auto_reload;
   logic [NUM_CNT_BITS-1:0] count_out;
   logic                    busy;
   logic                    done;

   modport master (
      output clear, start, count_enable, load_val, auto_reload,
      input  count_out, busy, done
   );

   modport slave (
      input  clear, start, count_enable, load_val, auto_reload,
      output count_out, busy, done
   );
endinterface

// File: rtl/flex_down_timer.sv
// ---------------------------------------------------------------------------
// flex_down_timer
// Load-and-count-down timer. A start request loads a period, the count is
// decremented on each count_enable tick, and done pulses for one cycle when
// the count reaches zero. A zero period completes immediately.
// Ports:
//   clk   : system clock, all state on the rising edge
//   n_rst : asynchronous active-low reset
//   bus   : flex_down_timer_if.slave (clear/start/count_enable/load_val/
//           auto_reload in, count_out/busy/done out, all outputs registered)
// Build option: define FLEX_DOWN_TIMER_RELOAD_EN to honour auto_reload, which
// reloads the latched period at each terminal tick and keeps the timer
// running (periodic strobe). Without it auto_reload has no effect.
// ---------------------------------------------------------------------------
module flex_down_timer #(
   parameter int NUM_CNT_BITS = 9
) (
   input  logic                 clk,
   input  logic                 n_rst,
   flex_down_timer_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = {NUM_CNT_BITS{1'b0}};
   localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

   state_t                  state_r, state_s;
   logic [NUM_CNT_BITS-1:0] count_r, count_s;
   logic [NUM_CNT_BITS-1:0] period_r, period_s;
   logic                    busy_r, busy_s;
   logic                    done_r, done_s;
   logic                    reload_s;

`ifdef FLEX_DOWN_TIMER_RELOAD_EN
   assign reload_s = bus.auto_reload;
`else
   // auto_reload and the latched period have no consumer in this build.
   logic unused_s;
   assign reload_s = 1'b0;
   assign unused_s = ^{bus.auto_reload, period_r};
`endif

   assign bus.count_out = count_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

   // State, count, period and output registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r  <= IDLE;
         count_r  <= CNT_ZERO;
         period_r <= CNT_ZERO;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         count_r  <= count_s;
         period_r <= period_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so that they can be registered alongside the state.
   always_comb begin
      state_s  = state_r;
      count_s  = count_r;
      period_s = period_r;
      busy_s   = busy_r;
      done_s   = 1'b0;

      if (bus.clear) begin
         state_s = IDLE;
         count_s = CNT_ZERO;
         busy_s  = 1'b0;
         done_s  = 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (bus.start) begin
                  if (bus.load_val != CNT_ZERO) begin
                     state_s  = RUN;
                     period_s = bus.load_val;
                     count_s  = bus.load_val;
                     busy_s   = 1'b1;
                  end else begin
                     // Zero period: complete straight away.
                     state_s = DONE;
                     count_s = CNT_ZERO;
                     busy_s  = 1'b0;
                     done_s  = 1'b1;
                  end
               end else begin
                  state_s = IDLE;
                  busy_s  = 1'b0;
               end
            end

            RUN: begin
               if (bus.count_enable) begin
                  if (count_r > CNT_ONE) begin
                     count_s = count_r - CNT_ONE;
                  end else if (reload_s) begin
                     // Terminal tick in periodic mode: strobe and restart.
                     count_s = period_r;
                     done_s  = 1'b1;
                  end else begin
                     // Terminal tick (count of 1); a count of 0 never
                     // occurs in RUN, so nothing can underflow here.
                     state_s = DONE;
                     count_s = CNT_ZERO;
                     busy_s  = 1'b0;
                     done_s  = 1'b1;
                  end
               end else begin
                  count_s = count_r;
               end
            end

            default: begin
               state_s = IDLE;
               count_s = CNT_ZERO;
               busy_s  = 1'b0;
               done_s  = 1'b0;
            end
         endcase
      end
   end

endmodule
